voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphony controller sitting between the note-event source (MIDI/MCU decoder) and a bank of NUM_VOICES DigitalOscillator instances.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to an oscillator voice.
- Drives every voice's enable and freq inputs from an internal voice table.
- When no voice is free, steals the oldest one.

Parameters:
- NUM_VOICES, 8, number of oscillator voices managed (2..16).
- FREQ_W, 11, width of a voice frequency word (matches oscillator freq input).
- KEY_W, 7, width of the note/key number.
- AGE_W, 4, width of the per-voice saturating age counter.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  KEY_W  key number of the event.
- ev_freq  in  FREQ_W  frequency word (used on note-on only).
- all_off  in  1  synchronous panic: silence all voices.
- voice_enable  out  NUM_VOICES  per-voice oscillator enable.
- voice_freq  out  NUM_VOICES*FREQ_W  packed per-voice freq; voice i at [i*FREQ_W +: FREQ_W].
- done  out  1  one-cycle pulse when an event has been committed.
- done_voice  out  clog2(NUM_VOICES)  voice affected by the committed event.
- done_hit  out  1  event changed the table; note-off with no matching key gives 0.
- done_steal  out  1  note-on evicted an active voice.

Behaviour:
- Reset (async, any state):
  - state=IDLE, ev_ready=1, done=0, done_voice=0, done_hit=0, done_steal=0.
  - All voice_enable=0, all voice_freq=0, all keys=0, all ages=0.
- Voice table, per voice: active bit, key, freq, age.
  - voice_enable[i] mirrors the active bit.
  - voice_freq mirrors the freq field.
  - Outputs are registered and change only in COMMIT or on all_off/reset.
- Handshake:
  - An event is accepted on a rising edge with ev_valid=1 and ev_ready=1.
  - ev_on, ev_key and ev_freq are latched at that edge.
  - ev_ready=1 only in IDLE.
- FSM states:
  - IDLE: on accept go to SCAN with idx=0.
  - SCAN: inspect voice idx, one voice per cycle, for exactly NUM_VOICES cycles, then go to COMMIT.
  - COMMIT: write the table, pulse done for one cycle, return to IDLE.
- Latency:
  - Table and outputs update at accept edge + NUM_VOICES + 1; done is high during the following cycle.
  - Back-to-back throughput is one event per NUM_VOICES + 2 cycles.
- Note-on selection, in priority order:
  - (1) Lowest-index active voice whose key equals ev_key: retrigger (freq updated, age=0, done_steal=0).
  - (2) Else the lowest-index inactive voice.
  - (3) Else the active voice with the largest age, ties to lowest index; done_steal=1.
- Note-on commit:
  - Chosen voice gets active=1, key=ev_key, freq=ev_freq, age=0.
  - Every other active voice increments its age, saturating at 2^AGE_W-1.
  - done_hit=1.
- Note-off commit:
  - The lowest-index active voice with a matching key is cleared: active=0; freq and key are retained.
  - Ages are unchanged.
  - No match: table unchanged, done_hit=0, done_voice=0.
- Inactive voices never increment age and are never matched by key.
- all_off:
  - Wins over everything except reset.
  - At the next edge all active=0 and ages=0; state goes to IDLE.
  - Any in-flight event is dropped, with no done pulse.
  - A simultaneous ev_valid is not accepted (ev_ready is forced 0 while all_off=1).
- Duplicate keys can only occur after a steal-free retrigger path fails, which cannot happen. Note-off must still handle them by clearing only the lowest index.
- voice_freq of zero with active=1 is legal; the oscillator outputs silence.

Test Plan:
- Reset mid-SCAN: assert reset 3 cycles after accepting a note-on (key 60, freq 440) -> next edge all outputs 0, ev_ready=1, no done pulse.
- Fill voices: 8 note-ons, keys 60..67, freq 100..107 -> voice i gets key 60+i.
  - Each done pulses 10 cycles after its accept, with done_voice=i, done_steal=0.
  - voice_enable=8'hFF.
  - Voice 0 age=7.
- Steal: after the fill, note-on key 70, freq 500 -> done_voice=0, done_steal=1, voice_freq[0]=500.
  - Repeat with key 71 -> done_voice=1.
- Retrigger and note-off: note-on key 62 with freq 999 while key 62 is on voice 2 -> done_voice=2, steal=0, freq[2]=999.
  - Then note-off key 62 -> voice_enable[2]=0.
  - Note-off key 90 -> done_hit=0, table unchanged.
- Free-slot reuse: with voices 0..3 active, turn off voice 1, then note-on key 80 -> done_voice=1.
- Panic: all_off pulsed during SCAN of an accepted event -> voice_enable=0 next edge, state IDLE, no done.
  - ev_valid held during all_off is not accepted.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to oscillator voices, stealing the oldest voice when none is free.
// Each event scans the voice table one voice per cycle, then commits in a single cycle.
module voice_allocator #(
   parameter int NUM_VOICES = 8,
   parameter int FREQ_W     = 11,
   parameter int KEY_W      = 7,
   parameter int AGE_W      = 4
) (
   input  logic                           CLK100MHZ,
   input  logic                           reset,
   input  logic                           ev_valid,
   output logic                           ev_ready,
   input  logic                           ev_on,
   input  logic [KEY_W-1:0]               ev_key,
   input  logic [FREQ_W-1:0]              ev_freq,
   input  logic                           all_off,
   output logic [NUM_VOICES-1:0]          voice_enable,
   output logic [NUM_VOICES*FREQ_W-1:0]   voice_freq,
   output logic                           done,
   output logic [$clog2(NUM_VOICES)-1:0]  done_voice,
   output logic                           done_hit,
   output logic                           done_steal
);
   localparam int IW = $clog2(NUM_VOICES);
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
   state_t r_state, w_next;
   logic [NUM_VOICES-1:0]             r_active;
   logic [NUM_VOICES-1:0][KEY_W-1:0]  r_vkey;
   logic [NUM_VOICES-1:0][FREQ_W-1:0] r_vfreq;
   logic [NUM_VOICES-1:0][AGE_W-1:0]  r_vage;
   logic [IW-1:0]     r_idx, r_midx, r_fidx, r_oidx;
   logic              r_mf, r_ff, r_of;
   logic [AGE_W-1:0]  r_oage;
   logic              r_on;
   logic [KEY_W-1:0]  r_key;
   logic [FREQ_W-1:0] r_freq;
   logic              r_done, r_dhit, r_dsteal;
   logic [IW-1:0]     r_dvoice;
   logic              w_accept, w_last, w_hit, w_older;
   logic [IW-1:0]     w_sel;
   assign ev_ready     = (r_state == S_IDLE) && !all_off;
   assign w_accept     = ev_valid && ev_ready;
   assign voice_enable = r_active;
   assign voice_freq   = r_vfreq;
   assign done         = r_done;
   assign done_voice   = r_dvoice;
   assign done_hit     = r_dhit;
   assign done_steal   = r_dsteal;
   always_comb begin
      w_last  = (r_idx == IW'(NUM_VOICES - 1));
      w_hit   = r_active[r_idx] && (r_vkey[r_idx] == r_key);
      w_older = r_active[r_idx] && (!r_of || r_vage[r_idx] > r_oage);
      w_sel   = r_mf ? r_midx : r_ff ? r_fidx : r_oidx;
      w_next  = all_off ? S_IDLE :
                (r_state == S_IDLE && w_accept) ? S_SCAN :
                (r_state == S_SCAN && w_last) ? S_COMMIT :
                (r_state == S_COMMIT) ? S_IDLE : r_state;
   end
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         r_active <= '0;
         r_vkey   <= '0;
         r_vfreq  <= '0;
         r_vage   <= '0;
         r_idx    <= '0;
         r_midx   <= '0;
         r_fidx   <= '0;
         r_oidx   <= '0;
         r_mf     <= 1'b0;
         r_ff     <= 1'b0;
         r_of     <= 1'b0;
         r_oage   <= '0;
         r_on     <= 1'b0;
         r_key    <= '0;
         r_freq   <= '0;
         r_done   <= 1'b0;
         r_dvoice <= '0;
         r_dhit   <= 1'b0;
         r_dsteal <= 1'b0;
      end else if (all_off) begin
         r_active <= '0;
         r_vage   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_on   <= ev_on;
            r_key  <= ev_key;
            r_freq <= ev_freq;
            r_idx  <= '0;
            r_mf   <= 1'b0;
            r_ff   <= 1'b0;
            r_of   <= 1'b0;
         end
         if (r_state == S_SCAN) begin
            r_idx <= r_idx + IW'(1);
            if (w_hit && !r_mf) begin
               r_mf   <= 1'b1;
               r_midx <= r_idx;
            end
            if (!r_active[r_idx] && !r_ff) begin
               r_ff   <= 1'b1;
               r_fidx <= r_idx;
            end
            if (w_older) begin
               r_of   <= 1'b1;
               r_oidx <= r_idx;
               r_oage <= r_vage[r_idx];
            end
         end
         if (r_state == S_COMMIT) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (r_on) begin
                  if (IW'(i) == w_sel) begin
                     r_active[i] <= 1'b1;
                     r_vkey[i]   <= r_key;
                     r_vfreq[i]  <= r_freq;
                     r_vage[i]   <= '0;
                  end else if (r_active[i] && r_vage[i] != '1) begin
                     r_vage[i] <= r_vage[i] + AGE_W'(1);
                  end
               end else if (r_mf && IW'(i) == r_midx) begin
                  r_active[i] <= 1'b0;
               end
            end
            r_done   <= 1'b1;
            r_dvoice <= r_on ? w_sel : (r_mf ? r_midx : '0);
            r_dhit   <= r_on || r_mf;
            r_dsteal <= r_on && !r_mf && !r_ff;
         end
      end
   end
endmodule
